// File: rtl/launchpad_scanner_pkg.sv
// Shared definitions for the launchpad key matrix: key codes, scanner FSM
// state encoding and the (row, col) -> key code map. The code-to-row/col
// encoder uses the same constants so both directions agree.
package launchpad_scanner_pkg;

    // Key codes as printed on the launchpad keycaps.
    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    // Scanner FSM states.
    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    // Physical position of a key -> its code.
    //   row0: 1 2 3 A
    //   row1: 4 5 6 B
    //   row2: 7 8 9 C
    //   row3: 0 F E D
    function automatic logic [3:0] rc_to_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = KEY_1;
            4'b00_01: code = KEY_2;
            4'b00_10: code = KEY_3;
            4'b00_11: code = KEY_A;
            4'b01_00: code = KEY_4;
            4'b01_01: code = KEY_5;
            4'b01_10: code = KEY_6;
            4'b01_11: code = KEY_B;
            4'b10_00: code = KEY_7;
            4'b10_01: code = KEY_8;
            4'b10_10: code = KEY_9;
            4'b10_11: code = KEY_C;
            4'b11_00: code = KEY_0;
            4'b11_01: code = KEY_F;
            4'b11_10: code = KEY_E;
            default:  code = KEY_D;
        endcase
        return code;
    endfunction

    // Index of the lowest active-low row; 0 when no row is low (callers
    // qualify it with an "any row low" test).
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_n[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/launchpad_sync.sv
// Two-flop synchronizer for the asynchronous, active-low row lines.
// Resets to all-ones so the scanner sees "no key" while coming out of reset.
module launchpad_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    // Two register stages; only q is allowed to fan out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 4'b1111;
            q    <= 4'b1111;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/launchpad_scanner.sv
// 4x4 launchpad key matrix scanner. Drives one column low at a time, samples
// the synchronized rows once per column dwell, debounces press and release,
// and reports the key code.
//
// Output protocol: key_valid is a one-cycle pulse that marks a newly accepted
// press; key_val is valid in that cycle and holds until the next accepted
// press. key_down is a level, high from acceptance until the release has been
// accepted. There is no back-pressure: the consumer must take the pulse.
module launchpad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_val,
    output logic       key_valid,
    output logic       key_down
);

    import launchpad_scanner_pkg::*;

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE);

    // With a single required sample, the detecting sample is also the
    // accepting one (and likewise for release).
    localparam bit SINGLE_SAMPLE = (DEBOUNCE == 1);

    // Synchronized rows; the raw pins are never looked at directly.
    logic [3:0]       rs;

    // Column dwell timing.
    logic [DIV_W-1:0] div;
    logic             sample;

    // Column currently driven.
    logic [1:0]       col;

    // FSM state and candidate key.
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [1:0]       cand_row;
    logic [1:0]       cand_col;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_done;

    // Row decode of the current sample.
    logic [1:0]       hit_row;
    logic             any_low;
    logic             cand_low;

    // Events decided at a sample point.
    logic             latch_cand;
    logic             accept;
    logic             release_done;
    logic             step_col;
    logic [3:0]       accept_code;

    launchpad_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_n),
        .q     (rs)
    );

    // Dwell counter: free-running 0..SCAN_DIV-1; the last count is the sample point.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign sample = (div == DIV_LAST);

    // Row decode: lowest low row wins, plus the level of the candidate's row.
    always_comb begin
        hit_row  = lowest_low_row(rs);
        any_low  = ~&rs;
        cand_low = ~rs[cand_row];
        cnt_inc  = cnt + CNT_ONE;
        cnt_done = (cnt_inc == CNT_TARGET);
    end

    // Next-state logic; nothing moves except at a sample point.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        latch_cand   = 1'b0;
        accept       = 1'b0;
        release_done = 1'b0;
        step_col     = 1'b0;
        if (sample) begin
            case (state)
                ST_SCAN: begin
                    if (any_low) begin
                        latch_cand = 1'b1;
                        cnt_next   = CNT_ONE;
                        if (SINGLE_SAMPLE) begin
                            accept     = 1'b1;
                            state_next = ST_HELD;
                        end else begin
                            state_next = ST_DEBOUNCE;
                        end
                    end else begin
                        step_col = 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    // The same key must still be the winning row.
                    if (cand_low && (hit_row == cand_row)) begin
                        cnt_next = cnt_inc;
                        if (cnt_done) begin
                            accept     = 1'b1;
                            state_next = ST_HELD;
                        end
                    end else begin
                        state_next = ST_SCAN;
                        step_col   = 1'b1;
                    end
                end
                ST_HELD: begin
                    // Only the held key's row matters; other keys are ignored.
                    if (!cand_low) begin
                        cnt_next = CNT_ONE;
                        if (SINGLE_SAMPLE) begin
                            release_done = 1'b1;
                            state_next   = ST_SCAN;
                            step_col     = 1'b1;
                        end else begin
                            state_next = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (!cand_low) begin
                        cnt_next = cnt_inc;
                        if (cnt_done) begin
                            release_done = 1'b1;
                            state_next   = ST_SCAN;
                            step_col     = 1'b1;
                        end
                    end else begin
                        // Bounce: back to held without a new pulse.
                        state_next = ST_HELD;
                    end
                end
                default: begin
                    state_next = ST_SCAN;
                end
            endcase
        end
    end

    // Code of the key being accepted; in SCAN the candidate is not latched yet.
    always_comb begin
        if (state == ST_SCAN) begin
            accept_code = rc_to_code(hit_row, col);
        end else begin
            accept_code = rc_to_code(cand_row, cand_col);
        end
    end

    // FSM state, debounce count and candidate key registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_SCAN;
            cnt      <= '0;
            cand_row <= 2'd0;
            cand_col <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (latch_cand) begin
                cand_row <= hit_row;
                cand_col <= col;
            end
        end
    end

    // Column pointer: advances only when the scanner is hunting for a key.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= 2'd0;
        end else if (step_col) begin
            col <= col + 2'd1;
        end
    end

    // Exactly one column driven low.
    always_comb begin
        col_n = ~(4'b0001 << col);
    end

    // Key outputs: pulse and code on acceptance, level until release accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_val   <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            key_valid <= accept;
            if (accept) begin
                key_val  <= accept_code;
                key_down <= 1'b1;
            end else if (release_done) begin
                key_down <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_launchpad_scanner.sv
// Bench for launchpad_scanner with SCAN_DIV=4, DEBOUNCE=2. A board model
// turns a set of pressed keys into row_n from the driven column; presses push
// their expected code, and a monitor checks every key_valid pulse against it.
module tb_launchpad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_val;
    logic       key_valid;
    logic       key_down;

    // pressed[row*4+col] = key physically held down.
    logic [15:0] pressed;

    // Keycap layout, row-major.
    logic [3:0] code_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                  4'h4, 4'h5, 4'h6, 4'hB,
                                  4'h7, 4'h8, 4'h9, 4'hC,
                                  4'h0, 4'hF, 4'hE, 4'hD};

    logic [3:0] exp_q[$];
    logic [3:0] last_code;
    logic       prev_valid;
    int         n_checks = 0;
    int         n_pass   = 0;

    launchpad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_val   (key_val),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    // Clock.
    always #5 clk = ~clk;

    // Board model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int i = 0; i < 16; i++) begin
            if (pressed[i] && !col_n[i % 4]) begin
                row_n[i / 4] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding press.
    always @(negedge clk) begin
        if (!reset && key_valid) begin
            if (prev_valid || exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: got pulse with key_val=%0h, expected no pulse", key_val);
            end else begin
                check("pulse_code", {28'd0, key_val}, {28'd0, exp_q.pop_front()});
                check("down_at_pulse", {31'd0, key_down}, 32'd1);
            end
        end
        prev_valid = key_valid && !reset;
    end

    // Bounded wait for key_down to reach a level; expiry is a failed check.
    task automatic wait_down(input logic lvl, input int budget, input string name);
        int k;
        k = 0;
        while (key_down !== lvl && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, key_down}, {31'd0, lvl});
    endtask

    // Clean press and release of a key set whose accepted code is known.
    task automatic press_keys(input logic [15:0] mask, input logic [3:0] code,
                              input int hold, input string name);
        pressed = mask;
        exp_q.push_back(code);
        wait_down(1'b1, 200, {name, "_down"});
        repeat (hold) @(negedge clk);
        check({name, "_held"}, {31'd0, key_down}, 32'd1);
        pressed = 16'h0;
        wait_down(1'b0, 200, {name, "_up"});
        check({name, "_val_kept"}, {28'd0, key_val}, {28'd0, code});
        last_code = code;
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [15:0] key_mask(input int r, input int c);
        logic [15:0] m;
        m = 16'h0;
        m[r * 4 + c] = 1'b1;
        return m;
    endfunction

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_col;
        int         k;
        int         idx;
        int         corner_r [5] = '{3, 3, 3, 0, 2};
        int         corner_c [5] = '{0, 1, 3, 3, 2};

        reset      = 1'b1;
        pressed    = 16'h0;
        last_code  = 4'h0;
        prev_valid = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_col_n", {28'd0, col_n}, 32'hE);
        check("rst_key_val", {28'd0, key_val}, 32'h0);
        check("rst_key_valid", {31'd0, key_valid}, 32'd0);
        check("rst_key_down", {31'd0, key_down}, 32'd0);

        // Idle scan: each column driven for SCAN_DIV cycles in order 0..3.
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            exp_col = ~(4'b0001 << ((i / SCAN_DIV) % 4));
            check("scan_col", {28'd0, col_n}, {28'd0, exp_col});
            @(negedge clk);
        end

        // Steady press at row1/col2.
        press_keys(key_mask(1, 2), code_tab[1 * 4 + 2], 10, "r1c2");

        // One-sample glitch on row2/col0: align to the first cycle of column 0.
        k = 0;
        while (col_n == 4'hE && k < 50) begin @(negedge clk); k++; end
        while (col_n != 4'hE && k < 50) begin @(negedge clk); k++; end
        check("glitch_align", {28'd0, col_n}, 32'hE);
        pressed = key_mask(2, 0);
        repeat (SCAN_DIV) @(negedge clk);
        pressed = 16'h0;
        repeat (SCAN_DIV) @(negedge clk);
        check("glitch_rescan_col", {28'd0, col_n}, 32'hD);
        check("glitch_key_down", {31'd0, key_down}, 32'd0);
        check("glitch_key_val", {28'd0, key_val}, {28'd0, last_code});

        // Code map corners.
        for (int i = 0; i < 5; i++) begin
            idx = corner_r[i] * 4 + corner_c[i];
            press_keys(key_mask(corner_r[i], corner_c[i]), code_tab[idx],
                       $urandom_range(0, 12), "corner");
        end

        // Rows 1 and 2 together in column 0: lowest row wins.
        pressed = key_mask(1, 0) | key_mask(2, 0);
        exp_q.push_back(code_tab[1 * 4 + 0]);
        wait_down(1'b1, 200, "multi_down");
        // Release bounce lasting exactly one sample, then re-press.
        pressed = 16'h0;
        repeat (SCAN_DIV) @(negedge clk);
        pressed = key_mask(1, 0) | key_mask(2, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("bounce_key_down", {31'd0, key_down}, 32'd1);
        end
        pressed = 16'h0;
        wait_down(1'b0, 200, "multi_up");
        check("multi_val", {28'd0, key_val}, {28'd0, code_tab[1 * 4 + 0]});
        last_code = code_tab[1 * 4 + 0];
        repeat (4) @(negedge clk);

        // Asynchronous reset while a key is held.
        pressed = key_mask(3, 2);
        exp_q.push_back(code_tab[3 * 4 + 2]);
        wait_down(1'b1, 200, "prerst_down");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_rst_key_down", {31'd0, key_down}, 32'd0);
        check("async_rst_col_n", {28'd0, col_n}, 32'hE);
        check("async_rst_key_val", {28'd0, key_val}, 32'h0);
        check("async_rst_key_valid", {31'd0, key_valid}, 32'd0);
        @(negedge clk);
        exp_q.push_back(code_tab[3 * 4 + 2]);
        reset = 1'b0;
        wait_down(1'b1, 200, "reacq_down");
        pressed = 16'h0;
        wait_down(1'b0, 200, "reacq_up");
        check("reacq_val", {28'd0, key_val}, {28'd0, code_tab[3 * 4 + 2]});
        repeat (4) @(negedge clk);

        // Random single-key presses with random start phase and hold time.
        for (int i = 0; i < 10; i++) begin
            idx = $urandom_range(0, 15);
            repeat ($urandom_range(0, 7)) @(negedge clk);
            press_keys(key_mask(idx / 4, idx % 4), code_tab[idx],
                       $urandom_range(0, 20), "random");
        end

        repeat (10) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
